// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then commits the access and holds the response until it is taken.
module dmem_responder #(
   parameter int                AWIDTH      = 32,
   parameter int                DWIDTH      = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h01000000),
   parameter int                DEPTH_BYTES = 4096,
   parameter int                LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_wdata_i,
   input  logic [2:0]        req_size_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DWIDTH-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [1:0]        dbg_state
);

   localparam int OW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the request side is ready only in IDLE, and the response is held until rsp_ready_i.
   state_t            state, state_next;
   logic [3:0]        cnt, cnt_next;
   logic              rst_sync;
   logic              accept;
   logic              enter_resp;

   logic              wr_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;
   logic [2:0]        size_q;

   logic              cur_wr;
   logic [AWIDTH-1:0] cur_addr;
   logic [DWIDTH-1:0] cur_wdata;
   logic [2:0]        cur_size;

   logic [2:0]        nbytes;
   logic              size_ok;
   logic              misaligned;
   logic              in_range;
   logic              acc_err;
   logic [AWIDTH-1:0] offset;
   logic [AWIDTH:0]   end_sum;
   logic [OW-1:0]     idx;
   logic [DWIDTH-1:0] load_val;
   logic [DWIDTH-1:0] load_ext;

   logic [DWIDTH-1:0] rdata_q;
   logic              err_q;

   logic [7:0]        mem [DEPTH_BYTES];

   // Release is registered once so the first acceptance lands on the second edge after it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= 1'b0;
      else      rst_sync <= 1'b1;
   end

   assign req_ready_o = (state == S_IDLE);
   assign accept      = req_valid_i && req_ready_o && rst_sync;
   assign rsp_valid_o = (state == S_RESP);
   assign rsp_rdata_o = (state == S_RESP) ? rdata_q : '0;
   assign rsp_err_o   = (state == S_RESP) ? err_q : 1'b0;
   assign dbg_state   = state;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      enter_resp = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_next = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = S_WAIT;
                  cnt_next   = 4'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_next = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= req_write_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
         size_q  <= req_size_i;
      end
   end

   // With zero latency the access happens on the acceptance edge, before capture settles.
   always_comb begin
      cur_wr    = (state == S_IDLE) ? req_write_i : wr_q;
      cur_addr  = (state == S_IDLE) ? req_addr_i  : addr_q;
      cur_wdata = (state == S_IDLE) ? req_wdata_i : wdata_q;
      cur_size  = (state == S_IDLE) ? req_size_i  : size_q;
   end

   always_comb begin
      nbytes  = 3'd0;
      size_ok = 1'b1;
      case (cur_size)
         3'b000, 3'b100: nbytes = 3'd1;
         3'b001, 3'b101: nbytes = 3'd2;
         3'b010:         nbytes = 3'd4;
         default:        size_ok = 1'b0;
      endcase
      misaligned = ((cur_size[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_size[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
      offset     = cur_addr - BASE_ADDR;
      end_sum    = {1'b0, offset} + (AWIDTH+1)'(nbytes);
      in_range   = (cur_addr >= BASE_ADDR) && (end_sum <= (AWIDTH+1)'(DEPTH_BYTES));
      acc_err    = !size_ok || misaligned || !in_range;
      idx        = offset[OW-1:0];
   end

   always_comb begin
      load_val = '0;
      if (!acc_err) begin
         for (int k = 0; k < 4; k++) begin
            if (k < int'(nbytes)) load_val[8*k +: 8] = mem[idx + OW'(k)];
         end
      end
      case (cur_size)
         3'b000:  load_ext = {{24{load_val[7]}}, load_val[7:0]};
         3'b001:  load_ext = {{16{load_val[15]}}, load_val[15:0]};
         default: load_ext = load_val;
      endcase
   end

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= (cur_wr || acc_err) ? '0 : load_ext;
         err_q   <= acc_err;
      end
   end

   // Storage is never reset; only a committed, legal store changes it.
   always_ff @(posedge clk) begin
      if (enter_resp && cur_wr && !acc_err) begin
         for (int k = 0; k < 4; k++) begin
            if (k < int'(nbytes)) mem[idx + OW'(k)] <= cur_wdata[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latency 2 and 0) driven with directed and random
// loads/stores, checked against a byte-array model of the memory map.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h01000000;
   localparam int          DEPTH = 4096;
   localparam int          LAT0  = 2;
   localparam int          LAT1  = 0;

   int lat [2] = '{LAT0, LAT1};

   logic             clk;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_write;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0][2:0]  req_size;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [1:0][31:0] rsp_rdata;
   logic [1:0]       rsp_err;
   logic [1:0][1:0]  dbg_state;

   logic [32:0] exp_q[$];
   logic [7:0]  mm [2][DEPTH];
   int          n_checks = 0;
   int          n_fail   = 0;

   dmem_responder #(.LATENCY(LAT0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
      .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_size_i(req_size[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
      .rsp_err_o(rsp_err[0]), .dbg_state(dbg_state[0])
   );

   dmem_responder #(.LATENCY(LAT1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
      .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_size_i(req_size[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
      .rsp_err_o(rsp_err[1]), .dbg_state(dbg_state[1])
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: byte-addressed memory map with size/alignment/range rules.
   function automatic void model(input int u, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] size,
                                 output logic [31:0] rd, output logic er);
      int     n;
      longint off;
      longint v;
      case (size)
         3'b000, 3'b100: n = 1;
         3'b001, 3'b101: n = 2;
         3'b010:         n = 4;
         default:        n = 0;
      endcase
      off = longint'(addr) - longint'(BASE);
      er  = (n == 0) || (off < 0) || (off + n > DEPTH) ||
            (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
      rd  = 32'h0;
      if (!er) begin
         if (wr) begin
            for (int i = 0; i < n; i++) mm[u][int'(off) + i] = wdata[8*i +: 8];
         end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(mm[u][int'(off) + i]) << (8 * i);
            if (size == 3'b000 && v > 127)   v -= 256;
            if (size == 3'b001 && v > 32767) v -= 65536;
            rd = v[31:0];
         end
      end
   endfunction

   // Driver: call at a falling edge; returns at the falling edge right after acceptance.
   task automatic send_req(input int u, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] size);
      logic [31:0] rd;
      logic        er;
      int          n;
      model(u, wr, addr, wdata, size, rd, er);
      exp_q.push_back({er, rd});
      req_valid[u] = 1'b1;
      req_write[u] = wr;
      req_addr[u]  = addr;
      req_wdata[u] = wdata;
      req_size[u]  = size;
      n = 0;
      while (!req_ready[u] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept_ready", 64'(req_ready[u]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid[u] = 1'b0;
      req_write[u] = 1'($urandom_range(0, 1));
      req_addr[u]  = $urandom;
      req_wdata[u] = $urandom;
      req_size[u]  = 3'($urandom_range(0, 7));
   endtask

   task automatic get_rsp(input int u, input int hold, output logic [31:0] rd, output logic er);
      int          n;
      logic [32:0] exp;
      logic [33:0] snap;
      n = 1;
      while (!rsp_valid[u] && n < 40) begin
         check_eq("busy_ready", 64'(req_ready[u]), 64'd0);
         check_eq("idle_rsp_zero", 64'({rsp_err[u], rsp_rdata[u]}), 64'd0);
         @(negedge clk);
         n++;
      end
      check_eq("rsp_valid", 64'(rsp_valid[u]), 64'd1);
      check_eq("latency", 64'(n), 64'(lat[u] + 1));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      rd  = rsp_rdata[u];
      er  = rsp_err[u];
      check_eq("rsp_data", 64'({rsp_err[u], rsp_rdata[u]}), 64'(exp));
      snap = {rsp_valid[u], rsp_err[u], rsp_rdata[u]};
      repeat (hold) begin
         @(negedge clk);
         check_eq("hold_stable", 64'({rsp_valid[u], rsp_err[u], rsp_rdata[u]}), 64'(snap));
         check_eq("hold_not_ready", 64'(req_ready[u]), 64'd0);
      end
      rsp_ready[u] = 1'b1;
      @(negedge clk);
      rsp_ready[u] = 1'b0;
      check_eq("post_rsp_idle", 64'({req_ready[u], rsp_valid[u]}), 64'b10);
      check_eq("post_rsp_zero", 64'({rsp_err[u], rsp_rdata[u]}), 64'd0);
   endtask

   task automatic txn(input int u, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size, input int hold,
                      output logic [31:0] rd, output logic er);
      send_req(u, wr, addr, wdata, size);
      get_rsp(u, hold, rd, er);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)       return BASE + 32'($urandom_range(0, 63));
      else if (r < 8)  return BASE + 32'(DEPTH - 16) + 32'($urandom_range(0, 15));
      else if (r == 8) return BASE - 32'd1 - 32'($urandom_range(0, 100));
      else             return BASE + 32'(DEPTH) + 32'($urandom_range(0, 100));
   endfunction

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] prior;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [32:0] dummy;

      rst       = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_size  = '0;
      rsp_ready = '0;
      #1;
      for (int u = 0; u < 2; u++) begin
         check_eq("reset_ready", 64'(req_ready[u]), 64'd1);
         check_eq("reset_valid", 64'(rsp_valid[u]), 64'd0);
         check_eq("reset_rsp", 64'({rsp_err[u], rsp_rdata[u]}), 64'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Preload the two address windows the random phase reads from.
      for (int u = 0; u < 2; u++) begin
         for (int off = 0; off < 64; off += 4)
            txn(u, 1'b1, BASE + 32'(off), $urandom, 3'b010, 0, rd, er);
         for (int off = DEPTH - 16; off < DEPTH; off += 4)
            txn(u, 1'b1, BASE + 32'(off), $urandom, 3'b010, 0, rd, er);
      end

      // Directed: word and byte accesses on the latency-2 instance.
      txn(0, 1'b1, 32'h01000010, 32'hDEADBEEF, 3'b010, 0, rd, er);
      check_eq("sw_rsp", 64'({er, rd}), 64'd0);
      txn(0, 1'b0, 32'h01000010, 32'h0, 3'b010, 0, rd, er);
      check_eq("lw_deadbeef", 64'(rd), 64'hDEADBEEF);
      txn(0, 1'b1, 32'h01000011, 32'h00000080, 3'b000, 0, rd, er);
      txn(0, 1'b0, 32'h01000011, 32'h0, 3'b000, 0, rd, er);
      check_eq("lb_sext", 64'(rd), 64'hFFFFFF80);
      txn(0, 1'b0, 32'h01000011, 32'h0, 3'b100, 0, rd, er);
      check_eq("lbu_zext", 64'(rd), 64'h00000080);
      txn(0, 1'b0, 32'h01000010, 32'h0, 3'b010, 0, rd, er);
      check_eq("lw_merged", 64'(rd), 64'hDEAD80EF);
      txn(0, 1'b0, 32'h01000001, 32'h0, 3'b001, 0, rd, er);
      check_eq("lh_misaligned", 64'({er, rd}), {31'd0, 1'b1, 32'd0});
      prior = {16'h0, mm[0][DEPTH-1], mm[0][DEPTH-2]};
      txn(0, 1'b1, BASE + 32'(DEPTH - 2), 32'h11223344, 3'b010, 0, rd, er);
      check_eq("sw_oob_err", 64'(er), 64'd1);
      txn(0, 1'b0, BASE + 32'(DEPTH - 2), 32'h0, 3'b101, 0, rd, er);
      check_eq("top_bytes_kept", 64'(rd), 64'(prior));
      txn(0, 1'b0, 32'h01000010, 32'h0, 3'b010, 5, rd, er);

      // Reset while a store waits: it must never reach storage.
      prior = {mm[0][35], mm[0][34], mm[0][33], mm[0][32]};
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h01000020;
      req_wdata[0] = 32'h12345678;
      req_size[0]  = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      check_eq("wait_not_ready", 64'(req_ready[0]), 64'd0);
      #2 rst = 1'b0;
      #1;
      check_eq("async_rst_ready", 64'(req_ready[0]), 64'd1);
      check_eq("async_rst_rsp", 64'({rsp_valid[0], rsp_err[0], rsp_rdata[0]}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model(0, 1'b0, 32'h01000020, 32'h0, 3'b010, rd, er);
      exp_q.push_back({er, rd});
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[0]  = 32'h01000020;
      req_size[0]  = 3'b010;
      @(posedge clk);
      @(negedge clk);
      check_eq("sync_edge1_idle", 64'(req_ready[0]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      check_eq("sync_edge2_accept", 64'(req_ready[0]), 64'd0);
      req_valid[0] = 1'b0;
      get_rsp(0, 0, rd, er);
      check_eq("lw_after_reset", 64'(rd), 64'(prior));

      // Directed on the zero-latency instance.
      txn(1, 1'b1, 32'h01000030, 32'hA5A55A5A, 3'b010, 0, rd, er);
      txn(1, 1'b0, 32'h01000030, 32'h0, 3'b010, 0, rd, er);
      check_eq("lat0_lw", 64'(rd), 64'hA5A55A5A);
      txn(1, 1'b0, 32'h01000032, 32'h0, 3'b001, 2, rd, er);
      check_eq("lat0_lh", 64'(rd), 64'hFFFFA5A5);

      // Random phase.
      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 150; k++) begin
            a  = rand_addr();
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
               if (sz[1:0] == 2'b01) a[0] = 1'b0;
               if (sz[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            txn(u, 1'($urandom_range(0, 1)), a, $urandom, sz, $urandom_range(0, 3), rd, er);
         end
      end

      check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
      dummy = '0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h01000000, first byte address served.
REQ-004 SHALL have parameter DEPTH_BYTES, default 4096, bytes of storage, a multiple of 4.
REQ-005 SHALL have parameter LATENCY, default 2, wait cycles between acceptance and response, range 0..15.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req_valid_i, input, 1, initiator presents a request.
REQ-010 SHALL have port req_ready_o, output, 1, responder can accept a request.
REQ-011 SHALL have port req_write_i, input, 1, 1 = store, 0 = load.
REQ-012 SHALL have port req_addr_i, input, AWIDTH, byte address.
REQ-013 SHALL have port req_wdata_i, input, DWIDTH, store data, right-aligned.
REQ-014 SHALL have port req_size_i, input, 3, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-015 SHALL have port rsp_valid_o, output, 1, response present.
REQ-016 SHALL have port rsp_ready_i, input, 1, initiator accepts the response.
REQ-017 SHALL have port rsp_rdata_o, output, DWIDTH, load result after extension.
REQ-018 SHALL have port rsp_err_o, output, 1, request was misaligned, out of range, or used an illegal size.

Function
REQ-019 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-020 SHALL assert req_ready_o only in IDLE; a request is accepted when req_valid_i & req_ready_o are both high on a rising edge.
REQ-021 SHALL capture write, addr, wdata and size at acceptance; later input changes have no effect.
REQ-022 On acceptance SHALL go to WAIT, load the wait counter with LATENCY-1, and decrement it each cycle; WAIT -> RESP when the counter is 0.
REQ-023 With LATENCY=0 SHALL go directly IDLE -> RESP.
REQ-024 rsp_valid_o SHALL first be high exactly LATENCY+1 cycles after the acceptance edge.
REQ-025 SHALL perform the storage access (read sample or store commit) on the edge that enters RESP.
REQ-026 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i is high on a rising edge; on that edge it goes to IDLE.
REQ-027 SHALL NOT accept a new request on the same edge a response completes; the minimum request spacing is LATENCY+2 cycles.
REQ-028 Offset = addr - BASE_ADDR; in range iff addr >= BASE_ADDR and offset + access size <= DEPTH_BYTES.
REQ-029 Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-030 Illegal size = size 011, 110 or 111.
REQ-031 On error SHALL leave storage unchanged and return rsp_rdata_o=0 with rsp_err_o=1.
REQ-032 Storage SHALL be little-endian; B stores write wdata[7:0], H stores write wdata[15:0], W stores write all 32 bits; other bytes are unchanged.
REQ-033 Loads SHALL be extended as follows: B sign-extends, BU zero-extends, H sign-extends, HU zero-extends, W is returned unchanged.
REQ-034 Store responses SHALL have rsp_rdata_o=0 and rsp_err_o=0 when legal.
REQ-035 rsp_rdata_o and rsp_err_o SHALL be 0 outside RESP.

Reset
REQ-036 Asserting rst low SHALL immediately force state IDLE, counter 0, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
REQ-037 A reset mid-transaction SHALL abandon it; a store not yet committed (before entering RESP) SHALL NOT modify storage.
REQ-038 Storage contents SHALL NOT be cleared by reset.
REQ-039 Deassertion of rst SHALL be synchronized to clk so that the first acceptance can occur on the second rising edge after release.

Verification
REQ-040 With LATENCY=2: SW 0xDEADBEEF at 0x01000010, then LW at the same address -> rsp_rdata_o=0xDEADBEEF; each rsp_valid_o rises 3 cycles after acceptance.
REQ-041 SB 0x80 at 0x01000011, then LB at 0x01000011 -> 0xFFFFFF80; LBU -> 0x00000080; LW at 0x01000010 -> 0xDEAD80EF.
REQ-042 LH at 0x01000001 -> rsp_err_o=1, rsp_rdata_o=0; SW at BASE_ADDR+DEPTH_BYTES-2 -> err=1 and the last two bytes are unchanged.
REQ-043 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o=0; on release, IDLE follows on the next edge.
REQ-044 Assert rst during WAIT of an SW 0x12345678 to 0x01000020 -> outputs reset immediately; a subsequent LW at 0x01000020 returns the prior contents.
REQ-045 With LATENCY=0, LW after SW -> rsp_valid_o is high 1 cycle after acceptance with the correct data.
